// File: rtl/gray_step_encoder.sv
// Debounced step counter with Gray/LED outputs and a multiplexed 2-digit decimal display; GRAY_WRAP_EN selects wrap instead of saturation.
// Latency: btn edge to count change is DEB_CYCLES+3 clocks from the first capturing edge; no backpressure.
module gray_step_encoder #(
    parameter int DEB_CYCLES     = 270000,
    parameter int REFRESH_CYCLES = 27000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic       dir,
    output logic [3:0] gray,
    output logic [3:0] binary,
    output logic [3:0] leds,
    output logic       uni,
    output logic       dec,
    output logic       segA,
    output logic       segB,
    output logic       segC,
    output logic       segD,
    output logic       segE,
    output logic       segF,
    output logic       segG
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);

`ifdef GRAY_WRAP_EN
    localparam logic WRAP = 1'b1;
`else
    localparam logic WRAP = 1'b0;
`endif

    logic          btn_s1, btn_s2;
    logic          dir_s1, dir_s2;
    logic [DW-1:0] deb_cnt;
    logic          deb_lvl;
    logic          deb_lvl_d;
    logic          step;
    logic [1:0]    fill;
    logic          mask;
    logic [3:0]    count;
    logic [3:0]    next_count;
    logic [RW-1:0] ref_cnt;
    logic          sel;

    always_comb begin
        next_count = count;
        if (dir_s2) begin
            if (count == 4'd15)
                next_count = WRAP ? 4'd0 : 4'd15;
            else
                next_count = count + 4'd1;
        end else begin
            if (count == 4'd0)
                next_count = WRAP ? 4'd15 : 4'd0;
            else
                next_count = count - 4'd1;
        end
    end

    // mask blocks the step from a press that was already held across reset;
    // it lifts once the synchronizer has refilled and shows the button released.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1    <= 1'b0;
            btn_s2    <= 1'b0;
            dir_s1    <= 1'b0;
            dir_s2    <= 1'b0;
            deb_cnt   <= '0;
            deb_lvl   <= 1'b0;
            deb_lvl_d <= 1'b0;
            step      <= 1'b0;
            fill      <= 2'b00;
            mask      <= 1'b1;
            count     <= 4'd0;
            ref_cnt   <= '0;
            sel       <= 1'b0;
        end else begin
            btn_s1    <= btn;
            btn_s2    <= btn_s1;
            dir_s1    <= dir;
            dir_s2    <= dir_s1;
            deb_lvl_d <= deb_lvl;
            step      <= deb_lvl & ~deb_lvl_d & ~mask;
            fill      <= {fill[0], 1'b1};

            if (btn_s2 == deb_lvl) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_lvl <= btn_s2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end

            if (fill[1] && !btn_s2)
                mask <= 1'b0;

            if (step)
                count <= next_count;

            if (ref_cnt == REF_LAST) begin
                ref_cnt <= '0;
                sel     <= ~sel;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end
        end
    end

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1111110;
            4'd1:    seg_of = 7'b0110000;
            4'd2:    seg_of = 7'b1101101;
            4'd3:    seg_of = 7'b1111001;
            4'd4:    seg_of = 7'b0110011;
            4'd5:    seg_of = 7'b1011011;
            4'd6:    seg_of = 7'b1011111;
            4'd7:    seg_of = 7'b1110000;
            4'd8:    seg_of = 7'b1111111;
            4'd9:    seg_of = 7'b1111011;
            default: seg_of = 7'b0000000;
        endcase
    endfunction

    logic       tens;
    logic [3:0] units;
    logic [3:0] digit;
    logic [6:0] seg;

    always_comb begin
        tens  = (count >= 4'd10);
        units = tens ? (count - 4'd10) : count;
        digit = sel ? {3'b000, tens} : units;
        // a leading zero on the tens digit is blanked rather than shown
        seg   = (sel && !tens) ? 7'b0000000 : seg_of(digit);
    end

    assign binary = count;
    assign gray   = count ^ (count >> 1);
    assign leds   = gray;
    assign uni    = ~sel;
    assign dec    = sel;
    assign {segA, segB, segC, segD, segE, segF, segG} = seg;

endmodule

// File: tb/tb_gray_step_encoder.sv
// Directed bench for gray_step_encoder; expected count changes are queued at press time and matched on output change.
module tb_gray_step_encoder;

    localparam int DEB = 4;
    localparam int REF = 8;

`ifdef GRAY_WRAP_EN
    localparam logic WRAP = 1'b1;
`else
    localparam logic WRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic       dir = 1'b1;
    logic [3:0] gray, binary, leds;
    logic       uni, dec;
    logic       segA, segB, segC, segD, segE, segF, segG;
    logic [6:0] segs;

    assign segs = {segA, segB, segC, segD, segE, segF, segG};

    gray_step_encoder #(.DEB_CYCLES(DEB), .REFRESH_CYCLES(REF)) dut (
        .clk(clk), .rst(rst), .btn(btn), .dir(dir),
        .gray(gray), .binary(binary), .leds(leds),
        .uni(uni), .dec(dec),
        .segA(segA), .segB(segB), .segC(segC), .segD(segD),
        .segE(segE), .segF(segF), .segG(segG)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] val;
        int         due;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [3:0] prev_bin = 4'd0;
    logic [3:0] model_bin = 4'd0;
    logic [3:0] gtab [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Posedge-numbered monitor: any count change outside reset must match the queue head.
    always @(posedge clk) begin
        logic r;
        exp_t e;
        cyc++;
        r = rst;
        #1;
        if (r) begin
            prev_bin = binary;
        end else if (binary !== prev_bin) begin
            if (sb.size() == 0) begin
                chk("unexpected_step", {28'd0, binary}, {28'd0, prev_bin});
            end else begin
                e = sb.pop_front();
                chk("step_value", {28'd0, binary}, {28'd0, e.val});
                chk("step_cycle", cyc, e.due);
            end
            prev_bin = binary;
        end
        if (!r) chk("digit_exclusive", {31'd0, uni & dec}, 32'd0);
    end

    function automatic logic [3:0] model_next(input logic up, input logic [3:0] b);
        if (up) return (b == 4'd15) ? (WRAP ? 4'd0 : 4'd15) : b + 4'd1;
        return (b == 4'd0) ? (WRAP ? 4'd15 : 4'd0) : b - 4'd1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        model_bin = 4'd0;
    endtask

    // The rise is captured on posedge cyc+1; the count moves 7 edges later.
    task automatic press(input logic up);
        logic [3:0] nx;
        @(negedge clk);
        dir = up;
        btn = 1'b1;
        nx = model_next(up, model_bin);
        if (nx !== model_bin) sb.push_back('{nx, cyc + 8});
        model_bin = nx;
        tick(12);
        btn = 1'b0;
        tick(10);
        chk("bin_after_press", {28'd0, binary}, {28'd0, model_bin});
    endtask

    task automatic wait_dec(input logic lvl);
        for (int k = 0; k < 40 && dec !== lvl; k++) @(negedge clk);
        chk("dec_reached", {31'd0, dec}, {31'd0, lvl});
    endtask

    initial begin
        int n;
        gtab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

        do_reset();
        chk("rst_binary", {28'd0, binary}, 32'd0);
        chk("rst_gray", {28'd0, gray}, 32'd0);
        chk("rst_leds", {28'd0, leds}, 32'd0);
        chk("rst_uni", {31'd0, uni}, 32'd1);
        chk("rst_dec", {31'd0, dec}, 32'd0);
        chk("rst_segs", {25'd0, segs}, {25'd0, 7'b1111110});

        // bounce: a 3-cycle glitch must be rejected, then a clean press counts once
        @(negedge clk);
        dir = 1'b1;
        btn = 1'b1;
        tick(3);
        btn = 1'b0;
        tick(5);
        btn = 1'b1;
        sb.push_back('{4'd1, cyc + 8});
        model_bin = 4'd1;
        tick(20);
        btn = 1'b0;
        tick(10);
        chk("bounce_binary", {28'd0, binary}, 32'd1);
        chk("bounce_gray", {28'd0, gray}, {28'd0, 4'b0001});

        do_reset();
        for (int i = 1; i <= 15; i++) begin
            press(1'b1);
            chk("sweep_gray", {28'd0, gray}, {28'd0, gtab[i]});
            chk("sweep_leds", {28'd0, leds}, {28'd0, gtab[i]});
            if (i == 12) begin
                wait_dec(1'b0);
                wait_dec(1'b1);
                chk("tens_1_segs", {25'd0, segs}, {25'd0, 7'b0110000});
                n = 0;
                while (dec === 1'b1 && n < 40) begin
                    n++;
                    @(negedge clk);
                end
                chk("dec_window", n, REF);
                chk("units_uni", {31'd0, uni}, 32'd1);
                chk("units_2_segs", {25'd0, segs}, {25'd0, 7'b1101101});
            end
        end

        press(1'b1);
        chk("limit_up", {28'd0, binary}, WRAP ? 32'd0 : 32'd15);
        do_reset();
        press(1'b0);
        chk("limit_down", {28'd0, binary}, WRAP ? 32'd15 : 32'd0);

        do_reset();
        for (int i = 0; i < 7; i++) press(1'b1);
        chk("seven_gray", {28'd0, gray}, {28'd0, 4'b0100});
        wait_dec(1'b1);
        chk("blank_tens", {25'd0, segs}, 32'd0);
        wait_dec(1'b0);
        chk("seven_segs", {25'd0, segs}, {25'd0, 7'b1110000});

        // press held across a reset must not count until released and pressed again
        do_reset();
        @(negedge clk);
        dir = 1'b1;
        btn = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        model_bin = 4'd0;
        tick(20);
        chk("held_rst_binary", {28'd0, binary}, 32'd0);
        btn = 1'b0;
        tick(10);
        chk("released_binary", {28'd0, binary}, 32'd0);
        press(1'b1);
        chk("repress_binary", {28'd0, binary}, 32'd1);

        tick(5);
        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
